// File: rtl/dsi_lanes_sequencer.sv
// DSI transmit PHY lane sequencer: LP buffer enables, clock-lane start/stop handshake, data grant.
// Optional macro DSI_CLK_AUTO_STOP_EN adds idle-timeout automatic clock stop.
module dsi_lanes_sequencer #(
    parameter int unsigned LANES           = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned CLK_PRE_CYCLES  = 8,
    parameter int unsigned CLK_POST_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT     = 200,
    parameter int unsigned IDLE_TIMEOUT    = 64
) (
    input  logic             clk_phy,
    input  logic             rst_n,
    input  logic             lines_enable,
    input  logic             clock_enable,
    input  logic [1:0]       reg_lanes_number,
    input  logic             clk_lane_active,
    input  logic [LANES-1:0] data_lane_active,
    input  logic             data_pending,
    output logic [LANES-1:0] dsi_lines_enable,
    output logic             clk_lines_enable,
    output logic             clk_start_rqst,
    output logic             clk_fin_rqst,
    output logic             tx_grant,
    output logic             lines_ready,
    output logic             clock_ready,
    output logic             lines_active,
    output logic             ack_error
);

    typedef enum logic [3:0] {
        StIdle,
        StEnableBuffers,
        StWaitClkOn,
        StClkPre,
        StLanesActive,
        StDrain,
        StClkPost,
        StWaitClkOff,
        StDisableBuffers
    } state_e;

    localparam logic [1:0]       MAX_LANE = 2'(LANES - 1);
    localparam logic [CNT_W-1:0] PRE_LIM  = CNT_W'(CLK_PRE_CYCLES);
    localparam logic [CNT_W-1:0] POST_LIM = CNT_W'(CLK_POST_CYCLES);
    localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lanes_q;
    logic [1:0]       lanes_clamped;
    logic [CNT_W-1:0] cnt_inc;
    logic             run_req;
    logic             stop_req;

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] n);
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            m[k] = (k <= int'(n));
        end
        return m;
    endfunction

    assign lanes_clamped = (reg_lanes_number > MAX_LANE) ? MAX_LANE : reg_lanes_number;
    assign cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef DSI_CLK_AUTO_STOP_EN
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    logic [CNT_W-1:0] idle_cnt;
    logic             idle_now;
    logic             idle_expired;

    assign idle_now     = !data_pending && !lines_active;
    assign idle_expired = idle_now && (idle_cnt >= IDLE_LIM);
    // Restart (or stop abort) needs real traffic, not just a running clock request.
    assign run_req      = clock_enable && data_pending && lines_enable;
    assign stop_req     = !clock_enable || !lines_enable || idle_expired;
`else
    logic unused_data_pending;
    logic unused_idle_timeout;

    assign unused_data_pending = data_pending;
    assign unused_idle_timeout = (IDLE_TIMEOUT == 0);
    assign run_req             = clock_enable && lines_enable;
    assign stop_req            = !clock_enable || !lines_enable;
`endif

    always_ff @(posedge clk_phy) begin
        if (!rst_n) begin
            state            <= StIdle;
            cnt              <= '0;
            lanes_q          <= '0;
            dsi_lines_enable <= '0;
            clk_lines_enable <= 1'b0;
            clk_start_rqst   <= 1'b0;
            clk_fin_rqst     <= 1'b0;
            tx_grant         <= 1'b0;
            lines_ready      <= 1'b0;
            clock_ready      <= 1'b0;
            lines_active     <= 1'b0;
            ack_error        <= 1'b0;
`ifdef DSI_CLK_AUTO_STOP_EN
            idle_cnt         <= '0;
`endif
        end else begin
            clk_start_rqst <= 1'b0;
            clk_fin_rqst   <= 1'b0;
            clock_ready    <= clk_lane_active;
            lines_active   <= |data_lane_active;
            unique case (state)
                StIdle: begin
                    if (lines_enable) begin
                        state            <= StEnableBuffers;
                        lanes_q          <= lanes_clamped;
                        dsi_lines_enable <= lane_mask(lanes_clamped);
                        clk_lines_enable <= 1'b1;
                        lines_ready      <= 1'b1;
                    end else begin
                        ack_error <= 1'b0;
                    end
                end
                StEnableBuffers: begin
                    if (!lines_enable) begin
                        state            <= StDisableBuffers;
                        dsi_lines_enable <= '0;
                        clk_lines_enable <= 1'b0;
                        lines_ready      <= 1'b0;
                    end else begin
                        dsi_lines_enable <= lane_mask(lanes_q);
                        if (run_req) begin
                            state          <= StWaitClkOn;
                            clk_start_rqst <= 1'b1;
                            cnt            <= '0;
                        end
                    end
                end
                StWaitClkOn: begin
                    if (clk_lane_active) begin
                        state <= StClkPre;
                        cnt   <= '0;
                    end else if (cnt >= ACK_LIM) begin
                        state     <= StEnableBuffers;
                        ack_error <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StClkPre: begin
                    if (cnt >= PRE_LIM) begin
                        state    <= StLanesActive;
                        tx_grant <= 1'b1;
`ifdef DSI_CLK_AUTO_STOP_EN
                        idle_cnt <= '0;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StLanesActive: begin
                    if (stop_req) begin
                        state    <= StDrain;
                        tx_grant <= 1'b0;
                    end
`ifdef DSI_CLK_AUTO_STOP_EN
                    if (idle_now) begin
                        idle_cnt <= (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + 1'b1;
                    end else begin
                        idle_cnt <= '0;
                    end
`endif
                end
                StDrain: begin
                    if (run_req) begin
                        state    <= StLanesActive;
                        tx_grant <= 1'b1;
`ifdef DSI_CLK_AUTO_STOP_EN
                        idle_cnt <= '0;
`endif
                    end else if (data_lane_active == '0) begin
                        state <= StClkPost;
                        cnt   <= '0;
                    end
                end
                StClkPost: begin
                    if (run_req) begin
                        state    <= StLanesActive;
                        tx_grant <= 1'b1;
`ifdef DSI_CLK_AUTO_STOP_EN
                        idle_cnt <= '0;
`endif
                    end else if (cnt >= POST_LIM) begin
                        state        <= StWaitClkOff;
                        clk_fin_rqst <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StWaitClkOff: begin
                    if (!clk_lane_active) begin
                        state <= StEnableBuffers;
                    end else if (cnt >= ACK_LIM) begin
                        state     <= StEnableBuffers;
                        ack_error <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StDisableBuffers: begin
                    if (!lines_enable) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/dsi_lanes_sequencer.md
# dsi_lanes_sequencer

Parametrised power-up, clock-lane and data-lane sequencer for the DSI transmit PHY. Sits between the register block / packet scheduler and the per-lane `dsi_lane_full` instances. It drives LP buffer enables per lane and start/finish requests to the clock lane. It gates data-lane transmission with programmable clock-pre/clock-post guard times, and reports lane status upward. It generalises the fixed 4-lane controller with a lane-count parameter, timed guard intervals, handshake timeout detection and optional automatic clock stop.

## Interface
Parameters:
- `LANES`, 4: number of data lanes instantiated, 1..4.
- `CNT_W`, 8: width of all guard/timeout counters.
- `CLK_PRE_CYCLES`, 8: clk_phy cycles between `clk_lane_active` rising and `tx_grant` asserting.
- `CLK_POST_CYCLES`, 8: clk_phy cycles between all data lanes idle and `clk_fin_rqst`.
- `ACK_TIMEOUT`, 200: max cycles to wait for `clk_lane_active` to change after a request.
- `IDLE_TIMEOUT`, 64: idle cycles before auto clock stop (only with `DSI_CLK_AUTO_STOP_EN`).

Ports (one clock; reset is synchronous and active-low):
- `clk_phy`  in  1  serial-data-domain clock, all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `lines_enable`  in  1  request LP buffers on.
- `clock_enable`  in  1  request HS clock running.
- `reg_lanes_number`  in  2  active data lanes minus one; values above LANES-1 clamp to LANES-1.
- `clk_lane_active`  in  1  clock lane in HS state.
- `data_lane_active`  in  LANES  per-lane HS transmission in progress.
- `data_pending`  in  1  any lane FIFO non-empty.
- `dsi_lines_enable`  out  LANES  per-data-lane LP buffer enable.
- `clk_lines_enable`  out  1  clock-lane LP buffer enable.
- `clk_start_rqst`  out  1  one-cycle pulse: start clock lane.
- `clk_fin_rqst`  out  1  one-cycle pulse: stop clock lane.
- `tx_grant`  out  1  data lanes may start HS bursts.
- `lines_ready`  out  1  buffers enabled (state not IDLE/DISABLE_BUFFERS).
- `clock_ready`  out  1  registered copy of `clk_lane_active`.
- `lines_active`  out  1  OR of `data_lane_active`.
- `ack_error`  out  1  sticky: clock lane handshake timed out; cleared by reset or `lines_enable`=0 in IDLE.

## Operation
- Lane count is latched from `reg_lanes_number` (clamped) on entry to ENABLE_BUFFERS; later changes are ignored until the next pass through IDLE.
- States and transitions:
  - IDLE: if `lines_enable`, go to ENABLE_BUFFERS.
  - ENABLE_BUFFERS: set `clk_lines_enable` and `dsi_lines_enable[k]` for k ≤ latched count. If `clock_enable`, pulse `clk_start_rqst` and go to WAIT_CLK_ON. If `lines_enable`=0, go to DISABLE_BUFFERS.
  - WAIT_CLK_ON: on `clk_lane_active`, go to CLK_PRE. If the counter reaches ACK_TIMEOUT, set `ack_error` and go to ENABLE_BUFFERS.
  - CLK_PRE: count CLK_PRE_CYCLES, then go to LANES_ACTIVE.
  - LANES_ACTIVE: `tx_grant`=1. If `clock_enable`=0 (or the auto-stop condition holds), go to DRAIN.
  - DRAIN: `tx_grant`=0. When `data_lane_active`==0, go to CLK_POST.
  - CLK_POST: count CLK_POST_CYCLES, pulse `clk_fin_rqst`, go to WAIT_CLK_OFF.
  - WAIT_CLK_OFF: on `clk_lane_active`=0, go to ENABLE_BUFFERS. Timeout sets `ack_error` and goes to ENABLE_BUFFERS.
  - DISABLE_BUFFERS: clear all buffer enables. Go to IDLE once `lines_enable`=0 (already 0 on entry, so one cycle).
- `clock_enable` reasserted during DRAIN/CLK_POST: aborts the stop. Go back to LANES_ACTIVE without a `clk_fin_rqst`.
- `lines_enable` deasserted while the clock runs: the stop sequence completes first, then buffers are disabled.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; latched count 0.
- All outputs registered, and change the cycle after the causing input is sampled.
- ENABLE_BUFFERS entry: buffer enables high 1 cycle after `lines_enable` is sampled high in IDLE.
- `tx_grant` rises exactly CLK_PRE_CYCLES+1 cycles after the first `clk_lane_active`=1 sample.
- `clk_fin_rqst` pulses exactly CLK_POST_CYCLES+1 cycles after `data_lane_active` is first sampled all-zero in DRAIN.
- Counters saturate and never wrap. CLK_PRE_CYCLES=0 or CLK_POST_CYCLES=0 means a single-cycle pass through the state.
- Reset asserted mid-operation: next edge returns everything to reset values, including mid-burst. Lanes must reset with the same `rst_n`.

## Configuration
- `DSI_CLK_AUTO_STOP_EN` defined: in LANES_ACTIVE, an idle counter increments while `data_pending`=0 and `lines_active`=0, and resets otherwise. At IDLE_TIMEOUT, go to DRAIN. In ENABLE_BUFFERS, `clock_enable`=1 with `data_pending`=1 restarts the clock. `clock_enable`=1 alone does not restart it.
- Undefined: clock runs continuously while `clock_enable`=1, and the idle counter and logic are not compiled in.

## Test plan
- Power-up with LANES=4, `reg_lanes_number`=1 → `dsi_lines_enable`=4'b0011 and `clk_lines_enable`=1 one cycle after `lines_enable`.
- `clock_enable`=1, `clk_lane_active` returned 3 cycles after `clk_start_rqst`, CLK_PRE_CYCLES=8 → `tx_grant` rises 9 cycles after `clk_lane_active`.
- Drop `clock_enable` while `data_lane_active`=4'b0001 for 20 cycles → `tx_grant` falls next cycle; `clk_fin_rqst` pulses CLK_POST_CYCLES+1 cycles after lane idle.
- Never assert `clk_lane_active`, ACK_TIMEOUT=200 → `ack_error`=1 at cycle 200 and state back in ENABLE_BUFFERS; `lines_enable`=0 clears it.
- `reg_lanes_number`=3 with LANES=2 → clamps to 2 lanes, `dsi_lines_enable`=2'b11; a change mid-LANES_ACTIVE has no effect.
- With `DSI_CLK_AUTO_STOP_EN`, IDLE_TIMEOUT=64, no data → clock stop starts after 64 idle cycles; `data_pending`=1 restarts it with a `clk_start_rqst` pulse.
